// File: rtl/ts_bus_sequencer.sv
// ts_bus_sequencer: round-robin read sequencer for the shared tri-state slave bus.
// One transaction at a time: drive the address for SETTLE cycles, sample Data,
// then park the bus at PARK_ADRS for TURN cycles before the next arbitration.
module ts_bus_sequencer #(
  parameter int                N_REQ     = 2,
  parameter int                ADRS_W    = 8,
  parameter int                SETTLE    = 1,
  parameter int                TURN      = 1,
  parameter logic [ADRS_W-1:0] PARK_ADRS = {ADRS_W{1'b1}},
  localparam int               ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADRS_W-1:0] req_adrs,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_data,
  output logic [ADRS_W-1:0]       bus_adrs,
  input  logic                    bus_data
);

  localparam int CMAX  = (SETTLE > TURN) ? SETTLE : TURN;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, TRN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     w_q, w_d;
  logic [ADRS_W-1:0]   adrs_q, adrs_d;

  logic [N_REQ-1:0]    gnt_d;
  logic                rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_d;
  logic                rsp_data_d;
  logic [ADRS_W-1:0]   bus_adrs_d;

  logic                found;
  logic [ID_W-1:0]     win;

  // Round-robin pick: first requester at or above rr_q, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    w_d         = w_q;
    adrs_d      = adrs_q;
    gnt_d       = gnt;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id;
    rsp_data_d  = rsp_data;
    bus_adrs_d  = bus_adrs;
    case (state_q)
      IDLE: begin
        bus_adrs_d = PARK_ADRS;
        if (found) begin
          w_d        = win;
          adrs_d     = req_adrs[int'(win)*ADRS_W +: ADRS_W];
          bus_adrs_d = req_adrs[int'(win)*ADRS_W +: ADRS_W];
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          cnt_d      = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        // Address is still on the bus this cycle; capture Data and release.
        rsp_data_d  = bus_data;
        rsp_id_d    = w_q;
        rsp_valid_d = 1'b1;
        gnt_d       = '0;
        rr_d        = (w_q == ID_W'(N_REQ - 1)) ? '0 : w_q + ID_W'(1);
        bus_adrs_d  = PARK_ADRS;
        cnt_d       = '0;
        state_d     = TRN;
      end
      TRN: begin
        if (cnt_q == CNT_W'(TURN - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        bus_adrs_d = PARK_ADRS;
        gnt_d      = '0;
        cnt_d      = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_q      <= '0;
      w_q       <= '0;
      adrs_q    <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 1'b0;
      bus_adrs  <= PARK_ADRS;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      w_q       <= w_d;
      adrs_q    <= adrs_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_data  <= rsp_data_d;
      bus_adrs  <= bus_adrs_d;
    end
  end

endmodule
